// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared widths and sequencer state type for the AES round controller
package aes_pkg;
    localparam int BLK_W  = 128;
    localparam int KIDX_W = 4;

    typedef enum logic [1:0] {IDLE, WHITEN, ROUND, DONE} aesState_t;
endpackage

// File: rtl/aes_round_cnt.sv
// rtl/aes_round_cnt.sv - round and datapath-latency counters; derives keyIdx, rndLast, roundDone
module aes_round_cnt
    import aes_pkg::*;
#(
    parameter int NR        = 10,
    parameter int ROUND_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              start,
    input  logic              inWhiten,
    input  logic              inRound,
    input  logic              dirInv,
    output logic              roundDone,
    output logic              rndLast,
    output logic [KIDX_W-1:0] keyIdx
);
    localparam logic [KIDX_W-1:0] NR_K   = KIDX_W'(NR);
    localparam logic [2:0]        LAT_TC = 3'(ROUND_LAT - 1);

    logic [KIDX_W-1:0] rnd;
    logic [2:0]        latCnt;

    assign roundDone = inRound && (latCnt == LAT_TC);
    assign rndLast   = inRound && (rnd == NR_K);

    // Decrypt walks the schedule backwards, whitening with the last key.
    always_comb begin
        keyIdx = '0;
        if (inWhiten) begin
            keyIdx = dirInv ? NR_K : '0;
        end else if (inRound) begin
            keyIdx = dirInv ? NR_K - rnd : rnd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd    <= '0;
            latCnt <= '0;
        end else if (clear) begin
            rnd    <= '0;
            latCnt <= '0;
        end else if (start) begin
            rnd    <= KIDX_W'(1);
            latCnt <= '0;
        end else if (roundDone) begin
            latCnt <= '0;
            rnd    <= (rnd == NR_K) ? '0 : rnd + 1'b1;
        end else if (inRound) begin
            latCnt <= latCnt + 1'b1;
        end
    end
endmodule

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - iterative AES round sequencer; optional abort input under AES_ROUND_CTRL_ABORT_EN
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR        = 10,
    parameter int ROUND_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef AES_ROUND_CTRL_ABORT_EN
    input  logic              abort,
`endif
    input  logic              inValid,
    output logic              inReady,
    input  logic              inv,
    input  logic [BLK_W-1:0]  dataIn,
    output logic              outValid,
    input  logic              outReady,
    output logic [BLK_W-1:0]  dataOut,
    output logic [KIDX_W-1:0] keyIdx,
    input  logic [BLK_W-1:0]  roundKey,
    output logic [BLK_W-1:0]  rndIn,
    output logic              rndInv,
    output logic              rndLast,
    input  logic [BLK_W-1:0]  rndOut
);
    aesState_t        fsm;
    logic [BLK_W-1:0] state;
    logic             abortReq;
    logic             accept;
    logic             roundDone;

`ifdef AES_ROUND_CTRL_ABORT_EN
    assign abortReq = abort;
`else
    assign abortReq = 1'b0;
`endif

    assign accept  = (fsm == IDLE) && inValid && inReady && !abortReq;
    assign rndIn   = state;
    assign dataOut = state;

    aes_round_cnt #(
        .NR        (NR),
        .ROUND_LAT (ROUND_LAT)
    ) uCnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (abortReq),
        .start     (accept),
        .inWhiten  (fsm == WHITEN),
        .inRound   (fsm == ROUND),
        .dirInv    (rndInv),
        .roundDone (roundDone),
        .rndLast   (rndLast),
        .keyIdx    (keyIdx)
    );

    // outValid trails entry into DONE by one cycle so the result is registered before it is offered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm      <= IDLE;
            state    <= '0;
            rndInv   <= 1'b0;
            inReady  <= 1'b1;
            outValid <= 1'b0;
        end else if (abortReq) begin
            fsm      <= IDLE;
            state    <= '0;
            rndInv   <= 1'b0;
            inReady  <= 1'b1;
            outValid <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (accept) begin
                        state   <= dataIn;
                        rndInv  <= inv;
                        inReady <= 1'b0;
                        fsm     <= WHITEN;
                    end
                end
                WHITEN: begin
                    state <= state ^ roundKey;
                    fsm   <= ROUND;
                end
                ROUND: begin
                    if (roundDone) begin
                        state <= rndOut;
                        if (rndLast) begin
                            fsm <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (outValid && outReady) begin
                        outValid <= 1'b0;
                        inReady  <= 1'b1;
                        fsm      <= IDLE;
                    end else begin
                        outValid <= 1'b1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule
